// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-index type used by the decode stage.
package cpu_pkg;

   localparam int DATA_W     = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;
   localparam bit ZERO_REG   = 1'b1;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with same-cycle write-through on both
// read ports. Register 0 can be hard-wired to zero.
module regfile_2r1w
   import cpu_pkg::*;
#(
   parameter int DATA_W     = cpu_pkg::DATA_W,
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter bit ZERO_REG   = cpu_pkg::ZERO_REG
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [REG_ADDR_W-1:0] raddr_a_i,
   input  logic [REG_ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0]     rdata_a_o,
   output logic [DATA_W-1:0]     rdata_b_o
);

   localparam int NREGS = 2 ** REG_ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic              wr_ok;

   // Writes aimed at a hard-wired zero register are discarded.
   assign wr_ok = we_i && !(ZERO_REG && (waddr_i == '0));

   // Storage: cleared on reset, one write per clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports: the word being written this cycle is visible immediately.
   always_comb begin
      rdata_a_o = regs_q[raddr_a_i];
      rdata_b_o = regs_q[raddr_b_i];
      if (wr_ok && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
      if (wr_ok && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
   end

endmodule

// File: rtl/rf_operand_fetch.sv
// Decode-stage operand fetch: register file read, MEM/WB bypass, load-use
// stall generation and the ID/EX pipeline register feeding the ALU.
module rf_operand_fetch
   import cpu_pkg::*;
#(
   parameter int DATA_W     = cpu_pkg::DATA_W,
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter bit ZERO_REG   = cpu_pkg::ZERO_REG
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_wreg,
   input  logic                  id_lw,
   input  logic                  flush,
   input  logic                  mem_valid,
   input  logic                  mem_wreg,
   input  logic                  mem_lw,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0]     mem_alu_out,
   input  logic                  wb_wen,
   input  logic [REG_ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0]     rf_wb_din,
   output logic                  stall_id,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic                  ex_wreg,
   output logic                  ex_lw
);

   logic [DATA_W-1:0]     rf_rs, rf_rt;
   logic [DATA_W-1:0]     rs_sel, rt_sel;
   logic                  mem_fwd_ok, ex_ld_pend, mem_ld_pend, hazard;

   logic                  ex_valid_q, ex_valid_d;
   logic                  ex_wreg_q, ex_wreg_d;
   logic                  ex_lw_q, ex_lw_d;
   logic [DATA_W-1:0]     ex_rs_q, ex_rs_d;
   logic [DATA_W-1:0]     ex_rt_q, ex_rt_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

   // Index 0 reads as zero regardless of any bypass; then MEM (younger) beats
   // the register file, whose output already includes the WB write-through.
   function automatic logic [DATA_W-1:0] operand(
      input logic [REG_ADDR_W-1:0] src,
      input logic [DATA_W-1:0]     rf_val,
      input logic                  mem_ok,
      input logic [REG_ADDR_W-1:0] mrd,
      input logic [DATA_W-1:0]     mval
   );
      if (ZERO_REG && (src == '0))      return '0;
      else if (mem_ok && (mrd == src))  return mval;
      else                              return rf_val;
   endfunction

   // A used, non-zero source that names a load still in EX or MEM must wait.
   function automatic logic src_hazard(
      input logic                  uses,
      input logic [REG_ADDR_W-1:0] src,
      input logic                  ex_pend,
      input logic [REG_ADDR_W-1:0] exrd,
      input logic                  mem_pend,
      input logic [REG_ADDR_W-1:0] mrd
   );
      if (!uses || (ZERO_REG && (src == '0))) return 1'b0;
      return (ex_pend && (exrd == src)) || (mem_pend && (mrd == src));
   endfunction

   regfile_2r1w #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .ZERO_REG   (ZERO_REG)
   ) u_rf (
      .clk       (clk),
      .reset     (reset),
      .we_i      (wb_wen),
      .waddr_i   (wb_waddr),
      .wdata_i   (rf_wb_din),
      .raddr_a_i (id_rs_addr),
      .raddr_b_i (id_rt_addr),
      .rdata_a_o (rf_rs),
      .rdata_b_o (rf_rt)
   );

   assign mem_fwd_ok  = mem_valid & mem_wreg & ~mem_lw;
   assign ex_ld_pend  = ex_valid_q & ex_lw_q & ex_wreg_q;
   assign mem_ld_pend = mem_valid & mem_lw & mem_wreg;

   // Operand bypass selection and load-use detection for the ID instruction.
   always_comb begin
      rs_sel = operand(id_rs_addr, rf_rs, mem_fwd_ok, mem_rd_addr, mem_alu_out);
      rt_sel = operand(id_rt_addr, rf_rt, mem_fwd_ok, mem_rd_addr, mem_alu_out);
      hazard = id_valid &
               (src_hazard(id_uses_rs, id_rs_addr, ex_ld_pend, ex_rd_q, mem_ld_pend, mem_rd_addr) |
                src_hazard(id_uses_rt, id_rt_addr, ex_ld_pend, ex_rd_q, mem_ld_pend, mem_rd_addr));
      // A flush kills the instruction, so it has nothing to wait for; reset
      // drops the request at once since the pipeline is being cleared.
      stall_id = hazard & ~flush & ~reset;
   end

   // ID/EX next state: bubble on flush or stall (payload held), else advance.
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_wreg_d  = ex_wreg_q;
      ex_lw_d    = ex_lw_q;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      ex_rd_d    = ex_rd_q;
      if (flush || stall_id) begin
         ex_valid_d = 1'b0;
         ex_wreg_d  = 1'b0;
         ex_lw_d    = 1'b0;
      end else begin
         ex_valid_d = id_valid;
         ex_wreg_d  = id_wreg & id_valid;
         ex_lw_d    = id_lw & id_valid;
         ex_rs_d    = rs_sel;
         ex_rt_d    = rt_sel;
         ex_rd_d    = id_rd_addr;
      end
   end

   // ID/EX pipeline register, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q <= 1'b0;
         ex_wreg_q  <= 1'b0;
         ex_lw_q    <= 1'b0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_rd_q    <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_wreg_q  <= ex_wreg_d;
         ex_lw_q    <= ex_lw_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_rd_q    <= ex_rd_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_wreg    = ex_wreg_q;
   assign ex_lw      = ex_lw_q;
   assign ex_rs_data = ex_rs_q;
   assign ex_rt_data = ex_rt_q;
   assign ex_rd_addr = ex_rd_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed bench for rf_operand_fetch: a per-cycle reference model plus
// hand-computed expectations for the key pipeline scenarios.
module tb_rf_operand_fetch;

   logic        clk;
   logic        reset;
   logic        id_valid, id_uses_rs, id_uses_rt, id_wreg, id_lw, flush;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic        mem_valid, mem_wreg, mem_lw;
   logic [4:0]  mem_rd_addr;
   logic [63:0] mem_alu_out;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [63:0] rf_wb_din;
   logic        stall_id, ex_valid, ex_wreg, ex_lw;
   logic [63:0] ex_rs_data, ex_rt_data;
   logic [4:0]  ex_rd_addr;

   int total = 0;
   int bad   = 0;

   rf_operand_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .id_valid    (id_valid),
      .id_rs_addr  (id_rs_addr),
      .id_rt_addr  (id_rt_addr),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .id_rd_addr  (id_rd_addr),
      .id_wreg     (id_wreg),
      .id_lw       (id_lw),
      .flush       (flush),
      .mem_valid   (mem_valid),
      .mem_wreg    (mem_wreg),
      .mem_lw      (mem_lw),
      .mem_rd_addr (mem_rd_addr),
      .mem_alu_out (mem_alu_out),
      .wb_wen      (wb_wen),
      .wb_waddr    (wb_waddr),
      .rf_wb_din   (rf_wb_din),
      .stall_id    (stall_id),
      .ex_valid    (ex_valid),
      .ex_rs_data  (ex_rs_data),
      .ex_rt_data  (ex_rt_data),
      .ex_rd_addr  (ex_rd_addr),
      .ex_wreg     (ex_wreg),
      .ex_lw       (ex_lw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_regs [32];
   logic        m_valid, m_wreg, m_lw;
   logic [63:0] m_rs, m_rt;
   logic [4:0]  m_rd;

   // Value an instruction would see for source s this cycle.
   function automatic logic [63:0] m_operand(input logic [4:0] s);
      if (s == 5'd0) return 64'd0;
      if (mem_valid && mem_wreg && !mem_lw && mem_rd_addr == s) return mem_alu_out;
      if (wb_wen && wb_waddr == s) return rf_wb_din;
      return m_regs[s];
   endfunction

   // True when source s depends on a load whose data is not yet in WB.
   function automatic bit m_waits(input logic uses, input logic [4:0] s);
      if (!uses || s == 5'd0) return 1'b0;
      return (m_valid && m_lw && m_wreg && m_rd == s) ||
             (mem_valid && mem_lw && mem_wreg && mem_rd_addr == s);
   endfunction

   // Compare process: stall checked mid-cycle, ex_* checked after the edge.
   initial begin
      bit e_stall;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_valid = 0; m_wreg = 0; m_lw = 0; m_rs = 0; m_rt = 0; m_rd = 0;
         end else begin
            e_stall = id_valid && !flush &&
                      (m_waits(id_uses_rs, id_rs_addr) || m_waits(id_uses_rt, id_rt_addr));
            chk("model stall_id", {63'd0, stall_id}, {63'd0, e_stall});
            if (flush || e_stall) begin
               m_valid = 0; m_wreg = 0; m_lw = 0;
            end else begin
               m_valid = id_valid;
               m_wreg  = id_wreg && id_valid;
               m_lw    = id_lw && id_valid;
               m_rs    = m_operand(id_rs_addr);
               m_rt    = m_operand(id_rt_addr);
               m_rd    = id_rd_addr;
            end
            if (wb_wen && wb_waddr != 5'd0) m_regs[wb_waddr] = rf_wb_din;
            @(posedge clk);
            #1;
            if (!reset) begin
               chk("model ex_valid",   {63'd0, ex_valid}, {63'd0, m_valid});
               chk("model ex_wreg",    {63'd0, ex_wreg},  {63'd0, m_wreg});
               chk("model ex_lw",      {63'd0, ex_lw},    {63'd0, m_lw});
               chk("model ex_rd_addr", {59'd0, ex_rd_addr}, {59'd0, m_rd});
               chk("model ex_rs_data", ex_rs_data, m_rs);
               chk("model ex_rt_data", ex_rt_data, m_rt);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rd_addr = 0; id_wreg = 0; id_lw = 0; flush = 0;
      mem_valid = 0; mem_wreg = 0; mem_lw = 0; mem_rd_addr = 0; mem_alu_out = 0;
      wb_wen = 0; wb_waddr = 0; rf_wb_din = 0;
   endtask

   task automatic id_inst(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt,
                          input logic [4:0] rd, input logic wr, input logic lw);
      id_valid = v; id_rs_addr = rs; id_uses_rs = urs; id_rt_addr = rt; id_uses_rt = urt;
      id_rd_addr = rd; id_wreg = wr; id_lw = lw;
   endtask

   task automatic mem_set(input logic v, input logic w, input logic l,
                          input logic [4:0] rd, input logic [63:0] val);
      mem_valid = v; mem_wreg = w; mem_lw = l; mem_rd_addr = rd; mem_alu_out = val;
   endtask

   task automatic wb_set(input logic en, input logic [4:0] a, input logic [63:0] d);
      wb_wen = en; wb_waddr = a; rf_wb_din = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic stall_is(input string name, input logic exp);
      #1;
      chk(name, {63'd0, stall_id}, {63'd0, exp});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      chk("reset ex_valid",   {63'd0, ex_valid}, 64'd0);
      chk("reset ex_wreg",    {63'd0, ex_wreg},  64'd0);
      chk("reset ex_lw",      {63'd0, ex_lw},    64'd0);
      chk("reset ex_rs_data", ex_rs_data, 64'd0);
      chk("reset ex_rt_data", ex_rt_data, 64'd0);
      chk("reset ex_rd_addr", {59'd0, ex_rd_addr}, 64'd0);
      chk("reset stall_id",   {63'd0, stall_id}, 64'd0);

      // Preload r1, r2.
      wb_set(1, 5'd1, 64'h11); tick();
      wb_set(1, 5'd2, 64'h22); tick();

      // Write-through r3 while ID reads it.
      idle();
      wb_set(1, 5'd3, 64'h1234);
      id_inst(1, 5'd3, 1, 5'd1, 1, 5'd9, 1, 0);
      stall_is("wt stall", 0);
      tick();
      chk("wt ex_rs_data", ex_rs_data, 64'h1234);
      chk("wt ex_rt_data", ex_rt_data, 64'h11);
      chk("wt ex_valid", {63'd0, ex_valid}, 64'd1);
      chk("wt ex_rd_addr", {59'd0, ex_rd_addr}, 64'd9);

      // MEM beats WB on the same source.
      idle();
      mem_set(1, 1, 0, 5'd7, 64'hAA);
      wb_set(1, 5'd7, 64'hBB);
      id_inst(1, 5'd2, 1, 5'd7, 1, 5'd11, 1, 0);
      tick();
      chk("memwb ex_rt_data", ex_rt_data, 64'hAA);
      chk("memwb ex_rs_data", ex_rs_data, 64'h22);
      idle();
      id_inst(1, 5'd0, 0, 5'd7, 1, 5'd12, 1, 0);
      tick();
      chk("r7 stored ex_rt_data", ex_rt_data, 64'hBB);

      // Load-use distance 1: two bubbles, then WB write-through.
      idle();
      id_inst(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
      tick();
      id_inst(1, 5'd4, 1, 5'd2, 1, 5'd5, 1, 0);
      stall_is("lu stall 1", 1);
      tick();
      chk("lu bubble 1", {63'd0, ex_valid}, 64'd0);
      mem_set(1, 1, 1, 5'd4, 64'h999);
      stall_is("lu stall 2", 1);
      tick();
      chk("lu bubble 2", {63'd0, ex_valid}, 64'd0);
      mem_set(0, 0, 0, 5'd0, 64'd0);
      wb_set(1, 5'd4, 64'hDEAD);
      stall_is("lu stall 3", 0);
      tick();
      chk("lu ex_valid", {63'd0, ex_valid}, 64'd1);
      chk("lu ex_rs_data", ex_rs_data, 64'hDEAD);
      chk("lu ex_rt_data", ex_rt_data, 64'h22);
      chk("lu ex_rd_addr", {59'd0, ex_rd_addr}, 64'd5);

      // Flush while a load-use hazard is present.
      idle();
      id_inst(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
      tick();
      id_inst(1, 5'd6, 1, 5'd0, 0, 5'd13, 1, 0);
      flush = 1;
      stall_is("flush stall", 0);
      tick();
      chk("flush ex_valid", {63'd0, ex_valid}, 64'd0);
      chk("flush ex_wreg",  {63'd0, ex_wreg},  64'd0);

      // Zero register: writes dropped, bypasses ignored, no stall.
      idle();
      wb_set(1, 5'd0, 64'hFFFF);
      id_inst(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
      tick();
      idle();
      id_inst(1, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0);
      mem_set(1, 1, 0, 5'd0, 64'h55);
      wb_set(1, 5'd0, 64'h77);
      stall_is("r0 stall ex-load", 0);
      tick();
      chk("r0 ex_rs_data", ex_rs_data, 64'd0);
      chk("r0 ex_rt_data", ex_rt_data, 64'd0);
      chk("r0 ex_valid", {63'd0, ex_valid}, 64'd1);
      idle();
      id_inst(1, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0);
      mem_set(1, 1, 1, 5'd0, 64'h55);
      stall_is("r0 stall mem-load", 0);
      tick();

      // Unused sources never stall.
      idle();
      id_inst(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1);
      tick();
      id_inst(1, 5'd8, 0, 5'd8, 0, 5'd15, 1, 0);
      stall_is("unused stall", 0);
      tick();
      chk("unused ex_valid", {63'd0, ex_valid}, 64'd1);

      // Reset in the middle of a stall clears everything without a clock.
      idle();
      wb_set(1, 5'd5, 64'h55AA);
      tick();
      idle();
      id_inst(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1);
      tick();
      id_inst(1, 5'd10, 1, 5'd0, 0, 5'd16, 1, 0);
      stall_is("pre-reset stall", 1);
      reset = 1'b1;
      #1;
      chk("async stall_id", {63'd0, stall_id}, 64'd0);
      chk("async ex_valid", {63'd0, ex_valid}, 64'd0);
      chk("async ex_lw", {63'd0, ex_lw}, 64'd0);
      chk("async ex_rd_addr", {59'd0, ex_rd_addr}, 64'd0);
      chk("async ex_rs_data", ex_rs_data, 64'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      idle();
      id_inst(1, 5'd5, 1, 5'd0, 0, 5'd17, 1, 0);
      tick();
      chk("post-reset r5", ex_rs_data, 64'd0);
      chk("post-reset ex_valid", {63'd0, ex_valid}, 64'd1);

      idle();
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Decode-stage operand-fetch block.
- Owns the 2-read/1-write register file and consumes the writeback data word produced at the end of the WB stage.
- Resolves RAW hazards by bypassing from MEM and WB, and stalls IF/ID on load-use.
- Registers operands and control into the ID/EX pipeline register that feeds the ALU.

Parameters:
- DATA_W, 64, register/data width
- REG_ADDR_W, 5, register index width (2**REG_ADDR_W registers)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs_addr  in  REG_ADDR_W  source A index
- id_rt_addr  in  REG_ADDR_W  source B index
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_rd_addr  in  REG_ADDR_W  destination index
- id_wreg  in  1  instruction writes rd
- id_lw  in  1  instruction is a load
- flush  in  1  kill the ID instruction (taken branch)
- mem_valid, mem_wreg, mem_lw  in  1 each  MEM-stage control
- mem_rd_addr  in  REG_ADDR_W  MEM destination
- mem_alu_out  in  DATA_W  MEM-stage ALU result
- wb_wen  in  1  WB write enable
- wb_waddr  in  REG_ADDR_W  WB destination
- rf_wb_din  in  DATA_W  WB data (load data / ALU result / immediate, already selected)
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_data  out  DATA_W  operand A
- ex_rt_data  out  DATA_W  operand B
- ex_rd_addr  out  REG_ADDR_W  destination
- ex_wreg  out  1  write-enable to carry down the pipe
- ex_lw  out  1  load flag to carry down the pipe

Behaviour:
- Reset (asynchronous, clears immediately, independent of clk):
  - All registers of the file are cleared to 0.
  - All ex_* outputs are 0; stall_id is 0.
- RF write: on the rising edge when wb_wen=1 and not (ZERO_REG and wb_waddr=0).
- RF read: combinational.
- Per-source operand selection, highest priority first:
  - (a) Index 0 with ZERO_REG=1 -> 0.
  - (b) mem_valid & mem_wreg & ~mem_lw & mem_rd_addr==src -> mem_alu_out.
  - (c) wb_wen & wb_waddr==src -> rf_wb_din (same-cycle write-through).
  - (d) RF array.
- Hazard (per used source, src!=0 when ZERO_REG=1):
  - haz_ex = ex_valid & ex_lw & ex_wreg & ex_rd_addr==src
  - haz_mem = mem_valid & mem_lw & mem_wreg & mem_rd_addr==src
  - hazard = id_valid & (haz_ex | haz_mem)
- stall_id = hazard & ~flush, combinational in the same cycle.
- ID/EX register update, on each clock edge:
  - flush=1: ex_valid<=0, ex_wreg<=0, ex_lw<=0. Data and address fields are don't-care but held.
  - else stall_id=1: insert bubble, same as flush. The ID instruction is re-presented next cycle by the held IF/ID.
  - else: ex_valid<=id_valid, ex_wreg<=id_wreg&id_valid, ex_lw<=id_lw&id_valid. Operands come from the selection above; ex_rd_addr<=id_rd_addr.
- Latency: one cycle from ID presentation to ex_* outputs.
- Load-use distance 1 -> 2 stall cycles; distance 2 -> 1 stall cycle; distance 3 -> WB write-through, no stall.
- Unused sources (id_uses_*=0) never cause a stall or forward; their data field is whatever is selected.
- Write to register 0 with ZERO_REG=1: dropped; a read returns 0 even when a bypass source targets index 0.
- MEM and WB both matching the same source: MEM wins (younger).
- Reset asserted mid-stall: the bubble is cleared and stall_id drops immediately.
- No backpressure beyond stall_id; downstream always accepts.

Decomposition:
- Shared package cpu_pkg: DATA_W, REG_ADDR_W, NUM_REGS, ZERO_REG constants, and a typedef for the register index.
- Sub-module regfile_2r1w: storage, async reset clear, write port, two combinational read ports, write-through.
- Forwarding, hazard detection and the ID/EX register stay in rf_operand_fetch.

Test Plan:
- Reset then read: assert reset mid-cycle -> ex_* all 0 without waiting for clk. Read r5 -> 0.
- Write-through: wb_wen=1, wb_waddr=3, rf_wb_din=0x1234, while ID reads rs=3 -> ex_rs_data=0x1234 the next cycle, no stall.
- MEM over WB: mem_rd_addr=7 with mem_alu_out=0xAA, and WB writing r7=0xBB, same cycle; ID reads rt=7 -> ex_rt_data=0xAA.
- Load-use distance 1: LW r4 then ADD using r4 -> stall_id=1 for exactly 2 cycles with ex_valid=0 bubbles. Third cycle: ex_rs_data = loaded value via WB.
- Flush during stall: hazard present and flush=1 -> stall_id=0, ex_valid=0 next cycle.
- Zero register: wb write r0=0xFFFF, then read r0 -> 0. MEM targeting r0 with 0x55 -> 0, no stall.
